// File: rtl/debounce_pkg.sv
// debounce_pkg: shared types and helpers for the time-multiplexed debouncer.
//   state_e  - scan sequencer states (IDLE waits for the scan tick, SCAN walks
//              the inputs one per clock).
//   width_of - bits needed to encode values 0..n-1, never less than one.
package debounce_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_e;

  function automatic int unsigned width_of(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/debounce_scheduler_rr_arbiter.sv
// rr_arbiter: combinational round-robin selector.
//   req   - request vector, one bit per input
//   ptr   - index searched first; the search wraps from N-1 back to 0
//   en    - when low no grant is produced
//   grant - index of the first requester found at or after ptr
//   valid - a requester was found (and en is high)
module rr_arbiter
  import debounce_pkg::*;
#(
  parameter int unsigned N = 4,
  localparam int unsigned W = width_of(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  input  logic         en,
  output logic [W-1:0] grant,
  output logic         valid
);

  always_comb begin
    grant = '0;
    valid = 1'b0;
    for (int unsigned k = 0; k < N; k++) begin
      int unsigned c;
      c = 32'(ptr) + k;
      if (c >= N) c = c - N;
      if (en && !valid && req[c]) begin
        valid = 1'b1;
        grant = W'(c);
      end
    end
  end

endmodule

// File: rtl/debounce_scheduler.sv
// debounce_scheduler: one shared counter/compare datapath sequenced over all
// switch inputs on a slow scan tick. Each accepted level change raises a
// pending flag that is reported as an event over a valid/ready port.
//   clock, reset (async, active low)
//   switch       - raw switch levels (synchronised internally)
//   switch_db    - debounced levels
//   event_valid/event_ready/event_index/event_level - change report handshake
//   overrun      - sticky, a change was accepted while its previous one was
//                  still unreported; overrun_clr clears it (set wins)
module debounce_scheduler
  import debounce_pkg::*;
#(
  parameter int unsigned INPUTS       = 16,
  parameter int unsigned TICK_DIV     = 50000,
  parameter int unsigned STABLE_COUNT = 4,
  localparam int unsigned IW = width_of(INPUTS)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [INPUTS-1:0] switch,
  output logic [INPUTS-1:0] switch_db,
  output logic              event_valid,
  input  logic              event_ready,
  output logic [IW-1:0]     event_index,
  output logic              event_level,
  output logic              overrun,
  input  logic              overrun_clr
);

  localparam int unsigned CW = width_of(STABLE_COUNT + 1);
  localparam int unsigned DW = width_of(TICK_DIV);

  logic [INPUTS-1:0] sync1_q, sync2_q;
  logic [DW-1:0]     div_q, div_d;
  state_e            state_q, state_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [CW-1:0]     cnt_q [INPUTS];
  logic [CW-1:0]     cnt_d [INPUTS];
  logic [INPUTS-1:0] db_q, db_d;
  logic [INPUTS-1:0] pend_q, pend_d;
  logic              ovr_q, ovr_d;
  logic              ev_valid_q, ev_valid_d;
  logic [IW-1:0]     ev_idx_q, ev_idx_d;
  logic              ev_lvl_q, ev_lvl_d;
  logic [IW-1:0]     ptr_q, ptr_d;

  logic              tick;
  logic              load;
  logic [IW-1:0]     gnt;
  logic              gnt_valid;
  logic [INPUTS-1:0] set_vec, clr_vec;
  logic              ovr_set;

  rr_arbiter #(.N(INPUTS)) u_arb (
    .req   (pend_q),
    .ptr   (ptr_q),
    .en    (load),
    .grant (gnt),
    .valid (gnt_valid)
  );

  assign tick = (div_q == DW'(TICK_DIV - 1));
  assign load = !ev_valid_q || event_ready;

  always_comb begin
    div_d      = tick ? '0 : div_q + DW'(1);
    state_d    = state_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    db_d       = db_q;
    set_vec    = '0;
    clr_vec    = '0;
    ovr_set    = 1'b0;
    ev_valid_d = ev_valid_q;
    ev_idx_d   = ev_idx_q;
    ev_lvl_d   = ev_lvl_q;
    ptr_d      = ptr_q;

    case (state_q)
      IDLE: begin
        if (tick) begin
          state_d = SCAN;
          idx_d   = '0;
        end
      end
      SCAN: begin
        if (sync2_q[idx_q] == db_q[idx_q]) begin
          cnt_d[idx_q] = '0;
        end else if (cnt_q[idx_q] == CW'(STABLE_COUNT - 1)) begin
          db_d[idx_q]    = sync2_q[idx_q];
          cnt_d[idx_q]   = '0;
          set_vec[idx_q] = 1'b1;
          ovr_set        = pend_q[idx_q];
        end else begin
          cnt_d[idx_q] = cnt_q[idx_q] + CW'(1);
        end
        if (idx_q == IW'(INPUTS - 1)) state_d = IDLE;
        else                          idx_d   = idx_q + IW'(1);
      end
      default: state_d = IDLE;
    endcase

    // Event register reloads whenever it is empty or being consumed; the
    // reported level is the registered one, so a same-cycle re-set of the
    // pending bit yields a follow-up event with the newer level.
    if (load) begin
      ev_valid_d = gnt_valid;
      if (gnt_valid) begin
        ev_idx_d     = gnt;
        ev_lvl_d     = db_q[gnt];
        clr_vec[gnt] = 1'b1;
        ptr_d        = (gnt == IW'(INPUTS - 1)) ? '0 : gnt + IW'(1);
      end
    end

    pend_d = (pend_q & ~clr_vec) | set_vec;
    ovr_d  = ovr_set ? 1'b1 : (overrun_clr ? 1'b0 : ovr_q);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      div_q      <= '0;
      state_q    <= IDLE;
      idx_q      <= '0;
      cnt_q      <= '{default: '0};
      db_q       <= '0;
      pend_q     <= '0;
      ovr_q      <= 1'b0;
      ev_valid_q <= 1'b0;
      ev_idx_q   <= '0;
      ev_lvl_q   <= 1'b0;
      ptr_q      <= '0;
    end else begin
      sync1_q    <= switch;
      sync2_q    <= sync1_q;
      div_q      <= div_d;
      state_q    <= state_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      db_q       <= db_d;
      pend_q     <= pend_d;
      ovr_q      <= ovr_d;
      ev_valid_q <= ev_valid_d;
      ev_idx_q   <= ev_idx_d;
      ev_lvl_q   <= ev_lvl_d;
      ptr_q      <= ptr_d;
    end
  end

  assign switch_db   = db_q;
  assign event_valid = ev_valid_q;
  assign event_index = ev_idx_q;
  assign event_level = ev_lvl_q;
  assign overrun     = ovr_q;

endmodule

// File: tb/tb_debounce_scheduler.sv
// Directed bench for debounce_scheduler with INPUTS=4, TICK_DIV=8,
// STABLE_COUNT=3. Inputs are driven and outputs sampled on the falling edge;
// cyc counts rising edges since the last reset release, so scan ticks land on
// edges 8,16,24,... and input i is sampled on edge 8k+1+i.
module tb_debounce_scheduler;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] switch = '0;
  logic [3:0] switch_db;
  logic       event_valid;
  logic       event_ready = 1'b0;
  logic [1:0] event_index;
  logic       event_level;
  logic       overrun;
  logic       overrun_clr = 1'b0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  debounce_scheduler #(
    .INPUTS       (4),
    .TICK_DIV     (8),
    .STABLE_COUNT (3)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .switch      (switch),
    .switch_db   (switch_db),
    .event_valid (event_valid),
    .event_ready (event_ready),
    .event_index (event_index),
    .event_level (event_level),
    .overrun     (overrun),
    .overrun_clr (overrun_clr)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clock);
    cyc++;
  endtask

  task automatic wait_to(input int n);
    while (cyc < n) step();
  endtask

  task automatic do_reset(input logic [3:0] sw, input logic rdy);
    reset = 1'b0;
    switch = sw;
    event_ready = rdy;
    overrun_clr = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    cyc = 0;
  endtask

  initial begin
    int n;
    logic saw_valid;
    logic [1:0] ri [8];
    logic       rl [8];

    // ---------------- reset and power-up acceptance
    do_reset(4'hF, 1'b1);
    reset = 1'b0;
    repeat (2) @(negedge clock);
    chk("rst_db", switch_db, 4'h0);
    chk("rst_valid", event_valid, 1'b0);
    chk("rst_index", event_index, 2'd0);
    chk("rst_level", event_level, 1'b0);
    chk("rst_overrun", overrun, 1'b0);
    reset = 1'b1;
    cyc = 0;
    wait_to(23); chk("pu_db_before_tick3", switch_db, 4'h0);
    wait_to(25); chk("pu_db_slot0", switch_db, 4'h1);
    chk("pu_valid_lag", event_valid, 1'b0);
    wait_to(26); chk("pu_ev0_valid", event_valid, 1'b1);
    chk("pu_ev0_index", event_index, 2'd0);
    chk("pu_ev0_level", event_level, 1'b1);
    wait_to(27); chk("pu_ev1_index", event_index, 2'd1);
    wait_to(28); chk("pu_ev2_index", event_index, 2'd2);
    chk("pu_db_full", switch_db, 4'hF);
    wait_to(29); chk("pu_ev3_index", event_index, 2'd3);
    chk("pu_ev3_level", event_level, 1'b1);
    wait_to(30); chk("pu_drain", event_valid, 1'b0);

    // ---------------- glitch of two samples on input 2
    do_reset(4'h0, 1'b1);
    switch = 4'b0100;
    wait_to(20);
    switch = 4'b0000;
    saw_valid = 1'b0;
    while (cyc < 40) begin
      step();
      if (event_valid) saw_valid = 1'b1;
      if (switch_db != 4'h0) saw_valid = 1'b1;
    end
    chk("glitch_db", switch_db, 4'h0);
    chk("glitch_no_event", saw_valid, 1'b0);

    // ---------------- backpressure
    do_reset(4'h0, 1'b0);
    switch = 4'b1010;
    wait_to(26); chk("bp_not_yet", event_valid, 1'b0);
    wait_to(27); chk("bp_valid", event_valid, 1'b1);
    chk("bp_index1", event_index, 2'd1);
    wait_to(35); chk("bp_hold_valid", event_valid, 1'b1);
    chk("bp_hold_index", event_index, 2'd1);
    chk("bp_hold_level", event_level, 1'b1);
    chk("bp_db", switch_db, 4'b1010);
    event_ready = 1'b1;
    wait_to(36); chk("bp_index3", event_index, 2'd3);
    chk("bp_valid3", event_valid, 1'b1);
    wait_to(37); chk("bp_empty", event_valid, 1'b0);
    event_ready = 1'b0;

    // ---------------- overrun
    do_reset(4'h0, 1'b0);
    switch = 4'b0001;
    wait_to(26); chk("ov_ev_index", event_index, 2'd0);
    chk("ov_ev_valid", event_valid, 1'b1);
    switch = 4'b0000;
    wait_to(49); chk("ov_db_fall", switch_db, 4'h0);
    chk("ov_not_yet", overrun, 1'b0);
    chk("ov_held_level", event_level, 1'b1);
    wait_to(50);
    switch = 4'b0001;
    wait_to(72); chk("ov_before", overrun, 1'b0);
    wait_to(73); chk("ov_set", overrun, 1'b1);
    chk("ov_db_rise", switch_db, 4'h1);
    wait_to(80); chk("ov_sticky", overrun, 1'b1);
    overrun_clr = 1'b1;
    step();
    overrun_clr = 1'b0;
    chk("ov_cleared", overrun, 1'b0);

    // ---------------- round-robin fairness
    do_reset(4'b0101, 1'b1);
    n = 0;
    while (cyc < 54) begin
      step();
      if (event_valid && event_ready && n < 8) begin
        ri[n] = event_index;
        rl[n] = event_level;
        n++;
      end
      if (cyc == 28) switch = 4'b0000;
    end
    chk("rr_count", n, 4);
    chk("rr_0_idx", ri[0], 2'd0); chk("rr_0_lvl", rl[0], 1'b1);
    chk("rr_1_idx", ri[1], 2'd2); chk("rr_1_lvl", rl[1], 1'b1);
    chk("rr_2_idx", ri[2], 2'd0); chk("rr_2_lvl", rl[2], 1'b0);
    chk("rr_3_idx", ri[3], 2'd2); chk("rr_3_lvl", rl[3], 1'b0);
    // input 1 is held in the output register while 0 and 3 queue up;
    // the pointer then sits at 2, so 3 must be served before 0
    event_ready = 1'b0;
    switch = 4'b0010;
    wait_to(60);
    switch = 4'b1011;
    wait_to(75); chk("rr_hold_idx", event_index, 2'd1);
    chk("rr_hold_valid", event_valid, 1'b1);
    wait_to(90); chk("rr_still_idx", event_index, 2'd1);
    event_ready = 1'b1;
    wait_to(91); chk("rr_wrap_first", event_index, 2'd3);
    wait_to(92); chk("rr_wrap_second", event_index, 2'd0);
    chk("rr_wrap_level", event_level, 1'b1);
    wait_to(93); chk("rr_wrap_empty", event_valid, 1'b0);

    // ---------------- asynchronous reset in the middle of a scan
    do_reset(4'b0101, 1'b0);
    wait_to(34);
    chk("ar_pre_valid", event_valid, 1'b1);
    chk("ar_pre_db", switch_db, 4'b0101);
    #1 reset = 1'b0;
    #1;
    chk("ar_db", switch_db, 4'h0);
    chk("ar_valid", event_valid, 1'b0);
    chk("ar_index", event_index, 2'd0);
    chk("ar_level", event_level, 1'b0);
    switch = 4'h0;
    event_ready = 1'b1;
    @(negedge clock);
    reset = 1'b1;
    cyc = 0;
    saw_valid = 1'b0;
    while (cyc < 40) begin
      step();
      if (event_valid) saw_valid = 1'b1;
    end
    chk("ar_no_event", saw_valid, 1'b0);
    chk("ar_db_after", switch_db, 4'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
